// File: rtl/int_to_float_encoder.sv
// Signed fixed-point to IEEE-754 single converter: shifts the magnitude left one bit
// per cycle until normalised, then rounds to nearest-even. One conversion in flight.
module int_to_float_encoder #(
  parameter int IN_W      = 32,
  parameter int FRAC_BITS = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic            out_inexact
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NORM  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // 127 bias + 31 (MSB position of the 32b magnitude) - binary point
  localparam logic [7:0] EXP_BASE = 8'(158 - FRAC_BITS);

  logic [1:0]  state;
  logic        sign;
  logic [31:0] mag;
  logic [7:0]  exp_r;

  logic [31:0] in_sext, in_mag;
  logic [22:0] mant;
  logic        guard, sticky, rnd_inc;
  logic [23:0] mant_sum;

  assign in_sext = 32'($signed(in_data));
  // -2^31 negates to itself, which is the correct unsigned magnitude
  assign in_mag  = in_sext[31] ? (~in_sext + 32'd1) : in_sext;

  assign mant     = mag[30:8];
  assign guard    = mag[7];
  assign sticky   = |mag[6:0];
  assign rnd_inc  = guard & (sticky | mant[0]);
  assign mant_sum = {1'b0, mant} + {23'd0, rnd_inc};

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sign        <= 1'b0;
      mag         <= '0;
      exp_r       <= '0;
      out_data    <= '0;
      out_inexact <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          sign  <= in_sext[31];
          mag   <= in_mag;
          exp_r <= EXP_BASE;
          if (in_mag == 32'd0) begin
            // zero always encodes as +0
            out_data    <= '0;
            out_inexact <= 1'b0;
            state       <= S_DONE;
          end else begin
            state <= S_NORM;
          end
        end
        S_NORM: begin
          if (mag[31]) state <= S_ROUND;
          else begin
            mag   <= mag << 1;
            exp_r <= exp_r - 8'd1;
          end
        end
        S_ROUND: begin
          // mantissa carry-out leaves mant_sum[22:0] at zero, only exp bumps
          out_data    <= {sign, exp_r + {7'd0, mant_sum[23]}, mant_sum[22:0]};
          out_inexact <= guard | sticky;
          state       <= S_DONE;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float_encoder.sv
// Directed bench for int_to_float_encoder: one instance with integer input and one
// with 8 fractional bits, sharing clock and reset.
module tb_int_to_float_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [2];
  logic [31:0] in_data   [2];
  logic        out_ready [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [31:0] out_data  [2];
  logic        out_inexact [2];

  int tests;
  int fails;

  int_to_float_encoder #(.IN_W(32), .FRAC_BITS(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_inexact(out_inexact[0])
  );

  int_to_float_encoder #(.IN_W(32), .FRAC_BITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_inexact(out_inexact[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one sample, count rising edges after the accept edge until out_valid is seen.
  task automatic offer(input int d, input logic [31:0] din, input int exp_edges, input string tag);
    int n;
    chk({tag, " in_ready"}, {31'd0, in_ready[d]}, 32'd1);
    in_valid[d] = 1'b1;
    in_data[d]  = din;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    n = 0;
    while (!out_valid[d] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, exp_edges);
  endtask

  task automatic conv(input int d, input logic [31:0] din, input logic [31:0] exp_data,
                      input logic exp_inx, input int exp_edges, input string tag);
    offer(d, din, exp_edges, tag);
    chk({tag, " data"}, out_data[d], exp_data);
    chk({tag, " inexact"}, {31'd0, out_inexact[d]}, {31'd0, exp_inx});
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    chk({tag, " valid drop"}, {31'd0, out_valid[d]}, 32'd0);
    chk({tag, " ready back"}, {31'd0, in_ready[d]}, 32'd1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b0;
    end
    #12;
    chk("reset in_ready",  {31'd0, in_ready[0]},    32'd1);
    chk("reset out_valid", {31'd0, out_valid[0]},   32'd0);
    chk("reset out_data",  out_data[0],             32'd0);
    chk("reset inexact",   {31'd0, out_inexact[0]}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // leading-zero count L gives L+2 edges of latency
    conv(0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 33, "one");
    conv(0, 32'h8000_0000, 32'hCF00_0000, 1'b0, 2,  "minint");
    conv(0, 32'h0000_0006, 32'h40C0_0000, 1'b0, 31, "six");
    conv(0, 32'h7FFF_FFFF, 32'h4F00_0000, 1'b1, 3,  "maxint");
    conv(0, 32'h0100_0001, 32'h4B80_0000, 1'b1, 9,  "tie_even");
    conv(0, 32'h0100_0003, 32'h4B80_0002, 1'b1, 9,  "tie_up");
    conv(0, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 33, "minus_one");
    // zero result is visible directly after the accept edge
    conv(0, 32'h0000_0000, 32'h0000_0000, 1'b0, 0,  "zero");
    conv(1, 32'h0000_0180, 32'h3FC0_0000, 1'b0, 25, "fx_1p5");
    conv(1, 32'hFFFF_FE80, 32'hBFC0_0000, 1'b0, 25, "fx_m1p5");

    // backpressure: result held, new samples ignored
    offer(0, 32'h0000_0006, 31, "bp");
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = i[0];
      in_data[0]  = 32'h0001_2345;
      @(posedge clk); #1;
      chk("bp valid", {31'd0, out_valid[0]}, 32'd1);
      chk("bp data",  out_data[0], 32'h40C0_0000);
      chk("bp ready", {31'd0, in_ready[0]}, 32'd0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk("bp release valid", {31'd0, out_valid[0]}, 32'd0);
    chk("bp release ready", {31'd0, in_ready[0]},  32'd1);
    @(posedge clk); #1;
    chk("bp single handshake", {31'd0, out_valid[0]}, 32'd0);

    // reset in the middle of normalisation
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h0000_0001;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst in_ready",  {31'd0, in_ready[0]},    32'd1);
    chk("midrst out_valid", {31'd0, out_valid[0]},   32'd0);
    chk("midrst out_data",  out_data[0],             32'd0);
    chk("midrst inexact",   {31'd0, out_inexact[0]}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst no stale", {31'd0, out_valid[0]}, 32'd0);
    conv(0, 32'h0000_0006, 32'h40C0_0000, 1'b0, 31, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
